// File: rtl/pattern_predictor_hist_pkg.sv
// Purpose: shared constants and saturating-counter helpers for the history predictor.
// Contents: mode encodings, default widths, ctr_update / ctr_init / sat_inc.
package pattern_pred_pkg;

  localparam logic MODE_BIMODAL = 1'b0;
  localparam logic MODE_HIST    = 1'b1;

  localparam int unsigned DEF_CTR_W  = 2;
  localparam int unsigned DEF_HIST_W = 4;
  localparam int unsigned DEF_CNT_W  = 8;

  // All-ones value of a w-bit counter, carried in a 32-bit container.
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Saturating increment on taken, saturating decrement otherwise.
  function automatic logic [31:0] ctr_update(input logic [31:0] ctr, input logic taken,
                                             input int unsigned w);
    if (taken) return (ctr == sat_max(w)) ? ctr : ctr + 32'd1;
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

  // Weak-not-taken: one below the midpoint, so the MSB reads 0.
  function automatic logic [31:0] ctr_init(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Statistics counter increment that holds at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    return (cnt == sat_max(w)) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/pattern_predictor_hist_if.sv
// Purpose: sample/prediction bus of the history predictor.
// Signals: in_valid, actual_pattern, mode, stat_clr (to predictor);
//          predicted_pattern, z_match, ghr, x_cnt, z_cnt (from predictor).
interface pattern_predictor_hist_if #(
  parameter int unsigned HIST_W = 4,
  parameter int unsigned CNT_W  = 8
) ();
  logic              in_valid;
  logic              actual_pattern;
  logic              mode;
  logic              stat_clr;
  logic              predicted_pattern;
  logic              z_match;
  logic [HIST_W-1:0] ghr;
  logic [CNT_W-1:0]  x_cnt;
  logic [CNT_W-1:0]  z_cnt;

  modport master (
    output in_valid, actual_pattern, mode, stat_clr,
    input  predicted_pattern, z_match, ghr, x_cnt, z_cnt
  );

  modport slave (
    input  in_valid, actual_pattern, mode, stat_clr,
    output predicted_pattern, z_match, ghr, x_cnt, z_cnt
  );
endinterface

// File: rtl/pattern_predictor_hist_table.sv
// Purpose: flop-based table of 2^HIST_W saturating counters.
// Ports: clk, reset (sync, active-high); i_rd_idx -> o_rd_msb (combinational read);
//        i_upd_en/i_upd_idx/i_upd_taken (synchronous saturating update).
module pred_counter_table
  import pattern_pred_pkg::*;
#(
  parameter int unsigned CTR_W  = DEF_CTR_W,
  parameter int unsigned HIST_W = DEF_HIST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HIST_W-1:0] i_rd_idx,
  output logic              o_rd_msb,
  input  logic              i_upd_en,
  input  logic [HIST_W-1:0] i_upd_idx,
  input  logic              i_upd_taken
);
  localparam int unsigned DEPTH = 1 << HIST_W;

  logic [CTR_W-1:0] r_tbl [DEPTH];

  // Whole table returns to weak-0 in a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tbl <= '{default: CTR_W'(ctr_init(CTR_W))};
    end else if (i_upd_en) begin
      r_tbl[i_upd_idx] <= CTR_W'(ctr_update(32'(r_tbl[i_upd_idx]), i_upd_taken, CTR_W));
    end
  end

  assign o_rd_msb = r_tbl[i_rd_idx][CTR_W-1];

endmodule

// File: rtl/pattern_predictor_hist.sv
// Purpose: history-indexed saturating-counter pattern predictor with hit statistics.
// Ports: clk, reset (sync, active-high); bus (slave): sample inputs, prediction,
//        match flag, global history and saturating sample/hit counters.
module pattern_predictor_hist
  import pattern_pred_pkg::*;
#(
  parameter int unsigned CTR_W  = DEF_CTR_W,
  parameter int unsigned HIST_W = DEF_HIST_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  pattern_predictor_hist_if.slave bus
);
  logic [HIST_W-1:0] r_ghr;
  logic [CNT_W-1:0]  r_x_cnt;
  logic [CNT_W-1:0]  r_z_cnt;
  logic [HIST_W-1:0] w_idx;
  logic              w_pred;
  logic              w_match;

  // Bimodal mode collapses onto entry 0; history keeps shifting regardless.
  assign w_idx   = (bus.mode == MODE_HIST) ? r_ghr : '0;
  assign w_match = bus.in_valid & (w_pred == bus.actual_pattern);

  pred_counter_table #(
    .CTR_W  (CTR_W),
    .HIST_W (HIST_W)
  ) u_tbl (
    .clk         (clk),
    .reset       (reset),
    .i_rd_idx    (w_idx),
    .o_rd_msb    (w_pred),
    .i_upd_en    (bus.in_valid),
    .i_upd_idx   (w_idx),
    .i_upd_taken (bus.actual_pattern)
  );

  // Truncating {ghr, bit} keeps the newest HIST_W bits, including HIST_W == 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr   <= '0;
      r_x_cnt <= '0;
      r_z_cnt <= '0;
    end else begin
      if (bus.in_valid) begin
        r_ghr <= HIST_W'({r_ghr, bus.actual_pattern});
      end
      if (bus.stat_clr) begin
        r_x_cnt <= '0;
        r_z_cnt <= '0;
      end else if (bus.in_valid) begin
        r_x_cnt <= CNT_W'(sat_inc(32'(r_x_cnt), CNT_W));
        if (w_match) begin
          r_z_cnt <= CNT_W'(sat_inc(32'(r_z_cnt), CNT_W));
        end
      end
    end
  end

  assign bus.predicted_pattern = w_pred;
  assign bus.z_match           = w_match;
  assign bus.ghr               = r_ghr;
  assign bus.x_cnt             = r_x_cnt;
  assign bus.z_cnt             = r_z_cnt;

endmodule

// File: tb/tb_pattern_predictor_hist.sv
// Purpose: directed self-checking bench for pattern_predictor_hist (defaults 2/4/8).
module tb_pattern_predictor_hist;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pattern_predictor_hist_if #(.HIST_W(4), .CNT_W(8)) bus ();

  pattern_predictor_hist #(
    .CTR_W  (2),
    .HIST_W (4),
    .CNT_W  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle.
  task automatic drive(input logic v, input logic a, input logic m, input logic c);
    bus.in_valid       = v;
    bus.actual_pattern = a;
    bus.mode           = m;
    bus.stat_clr       = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_pred", 32'(bus.predicted_pattern), 0);
    chk("rst_zm", 32'(bus.z_match), 0);
    chk("rst_ghr", 32'(bus.ghr), 0);
    chk("rst_x", 32'(bus.x_cnt), 0);
    chk("rst_z", 32'(bus.z_cnt), 0);
    chk("rst_tbl0", 32'(dut.u_tbl.r_tbl[0]), 1);

    // 1: bimodal, samples 1,1,0
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_pred0", 32'(bus.predicted_pattern), 0);
    chk("t1_zm0", 32'(bus.z_match), 0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_pred1", 32'(bus.predicted_pattern), 1);
    chk("t1_zm1", 32'(bus.z_match), 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_pred2", 32'(bus.predicted_pattern), 1);
    chk("t1_zm2", 32'(bus.z_match), 0);
    tick();
    chk("t1_x", 32'(bus.x_cnt), 3);
    chk("t1_z", 32'(bus.z_cnt), 1);
    chk("t1_tbl0", 32'(dut.u_tbl.r_tbl[0]), 2);
    chk("t1_ghr", 32'(bus.ghr), 6);

    // 2: six 1s saturate entry 0, then a 0 steps down to 2
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("t2_sat", 32'(dut.u_tbl.r_tbl[0]), 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_zm_miss", 32'(bus.z_match), 0);
    tick();
    chk("t2_after0", 32'(dut.u_tbl.r_tbl[0]), 2);
    chk("t2_pred", 32'(bus.predicted_pattern), 1);
    chk("t2_x", 32'(bus.x_cnt), 10);
    chk("t2_z", 32'(bus.z_cnt), 7);

    // 3: history mode learns alternating 1,0 (hits on samples 2,4 and 6..40)
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, logic'(k % 2), 1'b1, 1'b0);
      if (k == 1) chk("t3_pred_first", 32'(bus.predicted_pattern), 0);
      if (k >= 9) chk("t3_zm", 32'(bus.z_match), 1);
      tick();
    end
    chk("t3_x", 32'(bus.x_cnt), 40);
    chk("t3_z", 32'(bus.z_cnt), 37);
    chk("t3_ghr", 32'(bus.ghr), 4'hA);

    // 4: statistics saturate, then stat_clr beats a simultaneous sample
    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("t4_x_sat", 32'(bus.x_cnt), 255);
    chk("t4_z_sat", 32'(bus.z_cnt), 255);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_zm", 32'(bus.z_match), 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_x_clr", 32'(bus.x_cnt), 0);
    chk("t4_z_clr", 32'(bus.z_cnt), 0);
    chk("t4_tbl0", 32'(dut.u_tbl.r_tbl[0]), 0);
    chk("t4_ghr", 32'(bus.ghr), 0);

    // 5: build some state, then idle cycles with toggling inputs
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, logic'(k % 2), 1'b0, 1'b0);
      chk("t5_zm", 32'(bus.z_match), 0);
      tick();
    end
    chk("t5_ghr", 32'(bus.ghr), 3);
    chk("t5_tbl0", 32'(dut.u_tbl.r_tbl[0]), 2);
    chk("t5_x", 32'(bus.x_cnt), 2);
    chk("t5_z", 32'(bus.z_cnt), 0);
    chk("t5_pred", 32'(bus.predicted_pattern), 1);

    // 6: reset mid-run, with a valid sample presented alongside it
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, logic'((k / 3) % 2), 1'b1, 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_ghr", 32'(bus.ghr), 0);
    chk("t6_x", 32'(bus.x_cnt), 0);
    chk("t6_z", 32'(bus.z_cnt), 0);
    chk("t6_pred_hist", 32'(bus.predicted_pattern), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t6_tbl%0d", i), 32'(dut.u_tbl.r_tbl[i]), 1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_pred_bimodal", 32'(bus.predicted_pattern), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
